// File: rtl/dcache_store_buffer_pkg.sv
// Shared widths, store-entry layout and byte-lane merge helper for the DCache store buffer.
package dcache_store_buffer_pkg;
  localparam int NUM_COL    = 4;
  localparam int COL_WIDTH  = 8;
  localparam int ADDR_WIDTH = 10;
  localparam int DATA_WIDTH = NUM_COL * COL_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [NUM_COL-1:0]    be_t;
  typedef logic [DATA_WIDTH-1:0] data_t;

  typedef struct packed {
    addr_t addr;
    be_t   we;
    data_t data;
  } sb_entry_t;

  // Lanes with sel set take new_d; all other lanes keep old_d.
  function automatic data_t lane_merge(data_t old_d, data_t new_d, be_t sel);
    data_t r;
    r = old_d;
    for (int c = 0; c < NUM_COL; c++) begin
      if (sel[c]) r[c*COL_WIDTH +: COL_WIDTH] = new_d[c*COL_WIDTH +: COL_WIDTH];
    end
    return r;
  endfunction
endpackage

// File: rtl/dcache_store_buffer_if.sv
// CPU store/load port plus data-array read/write port of the store buffer.
interface dcache_store_buffer_if;
  import dcache_store_buffer_pkg::*;

  logic  st_valid;
  logic  st_ready;
  addr_t st_addr;
  be_t   st_we;
  data_t st_wdata;
  logic  ld_valid;
  addr_t ld_addr;
  logic  ld_rvalid;
  data_t ld_rdata;
  logic  wr_hold;
  logic  empty;
  logic  ram_ren;
  addr_t ram_raddr;
  logic  ram_wen;
  be_t   ram_we;
  addr_t ram_waddr;
  data_t ram_wdata;
  data_t ram_rdata;

  modport master (
    output st_valid, st_addr, st_we, st_wdata, ld_valid, ld_addr, wr_hold, ram_rdata,
    input  st_ready, ld_rvalid, ld_rdata, empty,
    input  ram_ren, ram_raddr, ram_wen, ram_we, ram_waddr, ram_wdata
  );

  modport slave (
    input  st_valid, st_addr, st_we, st_wdata, ld_valid, ld_addr, wr_hold, ram_rdata,
    output st_ready, ld_rvalid, ld_rdata, empty,
    output ram_ren, ram_raddr, ram_wen, ram_we, ram_waddr, ram_wdata
  );
endinterface

// File: rtl/dcache_sb_fwd.sv
// Combinational per-lane forwarding mux: youngest matching byte wins, same-cycle store above all entries.
module dcache_sb_fwd
  import dcache_store_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  sb_entry_t                  entries_i [DEPTH],
  input  logic [DEPTH-1:0]           valid_i,
  input  logic [$clog2(DEPTH)-1:0]   head_i,
  input  addr_t                      ld_addr_i,
  input  logic                       st_vld_i,
  input  sb_entry_t                  st_i,
  output be_t                        mask_o,
  output data_t                      data_o
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] idx;
  be_t              hit;

  // Walk from head (oldest) to youngest so later matches overwrite earlier ones.
  always_comb begin
    mask_o = '0;
    data_o = '0;
    idx    = '0;
    hit    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx    = head_i + PTR_W'(k);
      hit    = (valid_i[idx] && (entries_i[idx].addr == ld_addr_i)) ? entries_i[idx].we : '0;
      mask_o = mask_o | hit;
      data_o = lane_merge(data_o, entries_i[idx].data, hit);
    end
    hit    = (st_vld_i && (st_i.addr == ld_addr_i)) ? st_i.we : '0;
    mask_o = mask_o | hit;
    data_o = lane_merge(data_o, st_i.data, hit);
  end
endmodule

// File: rtl/dcache_store_buffer.sv
// Coalescing store FIFO draining one entry per cycle into the data array, with
// byte-wise store-to-load forwarding; loads take exactly 1 cycle and never stall.
module dcache_store_buffer
  import dcache_store_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic                  clock,
  input logic                  reset_n,
  dcache_store_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  sb_entry_t        entries_q [DEPTH];
  sb_entry_t        entries_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, young;
  logic [CNT_W-1:0] count_q, count_d;
  be_t              fwd_mask_q, fwd_mask_d, fwd_mask;
  data_t            fwd_data_q, fwd_data_d, fwd_data;
  logic             ld_rvalid_q;

  logic      is_empty, drain, merge_hit, st_fire, enq;
  sb_entry_t st_entry;

  assign st_entry = '{addr: bus.st_addr, we: bus.st_we, data: bus.st_wdata};
  assign young    = tail_q - PTR_W'(1);
  assign is_empty = (count_q == '0);
  assign drain    = !is_empty && !bus.wr_hold;
  // A lone entry leaving this cycle cannot absorb a store; the store gets a fresh slot.
  assign merge_hit = !is_empty && (entries_q[young].addr == bus.st_addr)
                     && !((count_q == CNT_W'(1)) && drain);
  assign bus.st_ready = (count_q < FULL_CNT) || merge_hit;
  assign st_fire      = bus.st_valid && bus.st_ready;
  assign enq          = st_fire && !merge_hit;

  always_comb begin
    entries_d = entries_q;
    valid_d   = valid_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    if (drain) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_W'(1);
    end
    if (enq) begin
      entries_d[tail_q] = st_entry;
      valid_d[tail_q]   = 1'b1;
      tail_d            = tail_q + PTR_W'(1);
    end
    if (st_fire && merge_hit) begin
      entries_d[young].we   = entries_q[young].we | bus.st_we;
      entries_d[young].data = lane_merge(entries_q[young].data, bus.st_wdata, bus.st_we);
    end
    if (enq && !drain)      count_d = count_q + CNT_W'(1);
    else if (!enq && drain) count_d = count_q - CNT_W'(1);
  end

  dcache_sb_fwd #(.DEPTH(DEPTH)) u_fwd (
    .entries_i (entries_q),
    .valid_i   (valid_q),
    .head_i    (head_q),
    .ld_addr_i (bus.ld_addr),
    .st_vld_i  (st_fire),
    .st_i      (st_entry),
    .mask_o    (fwd_mask),
    .data_o    (fwd_data)
  );

  assign fwd_mask_d = bus.ld_valid ? fwd_mask : '0;
  assign fwd_data_d = fwd_data;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      valid_q     <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      fwd_mask_q  <= '0;
      fwd_data_q  <= '0;
      ld_rvalid_q <= 1'b0;
    end else begin
      entries_q   <= entries_d;
      valid_q     <= valid_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      fwd_mask_q  <= fwd_mask_d;
      fwd_data_q  <= fwd_data_d;
      ld_rvalid_q <= bus.ld_valid;
    end
  end

  assign bus.empty     = is_empty;
  assign bus.ram_ren   = bus.ld_valid;
  assign bus.ram_raddr = bus.ld_addr;
  assign bus.ram_wen   = drain;
  assign bus.ram_we    = entries_q[head_q].we;
  assign bus.ram_waddr = entries_q[head_q].addr;
  assign bus.ram_wdata = entries_q[head_q].data;
  assign bus.ld_rvalid = ld_rvalid_q;
  assign bus.ld_rdata  = lane_merge(bus.ram_rdata, fwd_data_q, fwd_mask_q);
endmodule

// File: tb/tb_dcache_store_buffer.sv
// Bench for dcache_store_buffer: byte-enable RAM model plus scoreboards for drained writes and load data.
module tb_dcache_store_buffer;
  import dcache_store_buffer_pkg::*;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  dcache_store_buffer_if bus();

  dcache_store_buffer #(.DEPTH(4)) u_dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int failures = 0;

  sb_entry_t wr_exp[$];
  sb_entry_t wr_obs[$];
  data_t     ld_exp[$];

  data_t mem [1 << ADDR_WIDTH];
  logic  pre_en;
  addr_t pre_addr;
  data_t pre_data;

  always @(posedge clock) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    if (bus.ram_wen) mem[bus.ram_waddr] <= lane_merge(mem[bus.ram_waddr], bus.ram_wdata, bus.ram_we);
    if (bus.ram_ren) bus.ram_rdata <= mem[bus.ram_raddr];
  end

  always @(negedge clock) begin
    if (bus.ram_wen) wr_obs.push_back({bus.ram_waddr, bus.ram_we, bus.ram_wdata});
  end

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.st_valid = 1'b0;
    bus.st_addr  = '0;
    bus.st_we    = '0;
    bus.st_wdata = '0;
    bus.ld_valid = 1'b0;
    bus.ld_addr  = '0;
    pre_en       = 1'b0;
    pre_addr     = '0;
    pre_data     = '0;
  endtask

  task automatic put_store(addr_t a, be_t w, data_t d);
    bus.st_valid = 1'b1;
    bus.st_addr  = a;
    bus.st_we    = w;
    bus.st_wdata = d;
  endtask

  task automatic put_load(addr_t a, data_t expect_d);
    bus.ld_valid = 1'b1;
    bus.ld_addr  = a;
    ld_exp.push_back(expect_d);
  endtask

  task automatic preload(addr_t a, data_t d);
    idle();
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    cycle();
    pre_en = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.wr_hold = 1'b0;
    idle();
    repeat (2) cycle();
    @(negedge clock);
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL reset_empty: got %b expected 1", bus.empty); end
    checks++; if (bus.st_ready !== 1'b1) begin failures++; $display("FAIL reset_st_ready: got %b expected 1", bus.st_ready); end
    checks++; if (bus.ram_wen !== 1'b0) begin failures++; $display("FAIL reset_ram_wen: got %b expected 0", bus.ram_wen); end
    checks++; if (bus.ld_rvalid !== 1'b0) begin failures++; $display("FAIL reset_ld_rvalid: got %b expected 0", bus.ld_rvalid); end
    cycle();
    reset_n = 1'b1;
  endtask

  task automatic test_single_store();
    sb_entry_t oe, ee;
    put_store(10'h010, 4'hF, 32'h11223344);
    wr_exp.push_back({10'h010, 4'hF, 32'h11223344});
    @(negedge clock);
    checks++; if (bus.st_ready !== 1'b1) begin failures++; $display("FAIL single_ready: got %b expected 1", bus.st_ready); end
    cycle(); idle();
    @(negedge clock);
    checks++; if (bus.ram_wen !== 1'b1) begin failures++; $display("FAIL single_wen: got %b expected 1", bus.ram_wen); end
    checks++; if (bus.ram_waddr !== 10'h010) begin failures++; $display("FAIL single_waddr: got %h expected 010", bus.ram_waddr); end
    cycle();
    @(negedge clock);
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL single_empty: got %b expected 1", bus.empty); end
    cycle();
    checks++; if (wr_obs.size() != wr_exp.size()) begin failures++; $display("FAIL single_wr_count: got %0d expected %0d", wr_obs.size(), wr_exp.size()); end
    while (wr_exp.size() > 0 && wr_obs.size() > 0) begin
      ee = wr_exp.pop_front(); oe = wr_obs.pop_front();
      checks++; if (oe !== ee) begin failures++; $display("FAIL single_wr: got %h expected %h", oe, ee); end
    end
    wr_exp.delete(); wr_obs.delete();
  endtask

  task automatic test_full();
    sb_entry_t oe, ee;
    logic exp_r;
    bus.wr_hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      put_store(10'h100 + 10'(i), 4'hF, 32'hA0A0A0A0 + 32'(i));
      exp_r = (i < 4);
      if (i < 4) wr_exp.push_back({10'h100 + 10'(i), 4'hF, 32'hA0A0A0A0 + 32'(i)});
      @(negedge clock);
      checks++; if (bus.st_ready !== exp_r) begin failures++; $display("FAIL full_ready_%0d: got %b expected %b", i, bus.st_ready, exp_r); end
      cycle();
    end
    // full, but the youngest entry can still absorb a store
    put_store(10'h103, 4'b0010, 32'h0000EE00);
    wr_exp[3] = {10'h103, 4'hF, 32'hA0A0EEA3};
    @(negedge clock);
    checks++; if (bus.st_ready !== 1'b1) begin failures++; $display("FAIL full_merge_ready: got %b expected 1", bus.st_ready); end
    cycle();
    bus.wr_hold = 1'b0;
    put_store(10'h1FF, 4'hF, 32'h55555555);
    @(negedge clock);
    checks++; if (bus.st_ready !== 1'b0) begin failures++; $display("FAIL full_no_bypass: got %b expected 0", bus.st_ready); end
    checks++; if (bus.ram_wen !== 1'b1) begin failures++; $display("FAIL full_drain0: got %b expected 1", bus.ram_wen); end
    cycle(); idle();
    for (int i = 1; i < 4; i++) begin
      @(negedge clock);
      checks++; if (bus.ram_wen !== 1'b1) begin failures++; $display("FAIL full_drain%0d: got %b expected 1", i, bus.ram_wen); end
      cycle();
    end
    @(negedge clock);
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL full_empty: got %b expected 1", bus.empty); end
    cycle();
    checks++; if (wr_obs.size() != wr_exp.size()) begin failures++; $display("FAIL full_wr_count: got %0d expected %0d", wr_obs.size(), wr_exp.size()); end
    while (wr_exp.size() > 0 && wr_obs.size() > 0) begin
      ee = wr_exp.pop_front(); oe = wr_obs.pop_front();
      checks++; if (oe !== ee) begin failures++; $display("FAIL full_wr: got %h expected %h", oe, ee); end
    end
    wr_exp.delete(); wr_obs.delete();
  endtask

  task automatic test_coalesce();
    sb_entry_t oe, ee;
    bus.wr_hold = 1'b1;
    put_store(10'h020, 4'b0001, 32'h000000AA);
    @(negedge clock); cycle();
    put_store(10'h020, 4'b0100, 32'h00BB0000);
    @(negedge clock);
    checks++; if (bus.st_ready !== 1'b1) begin failures++; $display("FAIL coal_ready: got %b expected 1", bus.st_ready); end
    cycle(); idle();
    bus.wr_hold = 1'b0;
    wr_exp.push_back({10'h020, 4'b0101, 32'h00BB00AA});
    @(negedge clock);
    checks++; if (bus.ram_we !== 4'b0101) begin failures++; $display("FAIL coal_we: got %b expected 0101", bus.ram_we); end
    cycle();
    @(negedge clock);
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL coal_single_entry: got empty=%b expected 1", bus.empty); end
    cycle();
    checks++; if (wr_obs.size() != wr_exp.size()) begin failures++; $display("FAIL coal_wr_count: got %0d expected %0d", wr_obs.size(), wr_exp.size()); end
    while (wr_exp.size() > 0 && wr_obs.size() > 0) begin
      ee = wr_exp.pop_front(); oe = wr_obs.pop_front();
      checks++; if (oe !== ee) begin failures++; $display("FAIL coal_wr: got %h expected %h", oe, ee); end
    end
    wr_exp.delete(); wr_obs.delete();
  endtask

  task automatic test_forward();
    sb_entry_t oe, ee;
    data_t ed;
    preload(10'h030, 32'hDEADBEEF);
    bus.wr_hold = 1'b1;
    put_store(10'h030, 4'b0011, 32'h00001234);
    @(negedge clock); cycle(); idle();
    put_load(10'h030, 32'hDEAD1234);
    @(negedge clock); cycle(); idle();
    @(negedge clock);
    checks++; if (bus.ld_rvalid !== 1'b1) begin failures++; $display("FAIL fwd_rvalid: got %b expected 1", bus.ld_rvalid); end
    ed = ld_exp.pop_front();
    checks++; if (bus.ld_rdata !== ed) begin failures++; $display("FAIL fwd_partial: got %h expected %h", bus.ld_rdata, ed); end
    cycle();
    put_store(10'h030, 4'b1000, 32'h77000000);
    put_load(10'h030, 32'h77AD1234);
    @(negedge clock); cycle(); idle();
    @(negedge clock);
    ed = ld_exp.pop_front();
    checks++; if (bus.ld_rdata !== ed) begin failures++; $display("FAIL fwd_same_cycle: got %h expected %h", bus.ld_rdata, ed); end
    cycle();
    bus.wr_hold = 1'b0;
    wr_exp.push_back({10'h030, 4'b1011, 32'h77001234});
    cycle();
    put_load(10'h030, 32'h77AD1234);
    @(negedge clock); cycle(); idle();
    @(negedge clock);
    ed = ld_exp.pop_front();
    checks++; if (bus.ld_rdata !== ed) begin failures++; $display("FAIL fwd_after_drain: got %h expected %h", bus.ld_rdata, ed); end
    cycle();
    checks++; if (wr_obs.size() != wr_exp.size()) begin failures++; $display("FAIL fwd_wr_count: got %0d expected %0d", wr_obs.size(), wr_exp.size()); end
    while (wr_exp.size() > 0 && wr_obs.size() > 0) begin
      ee = wr_exp.pop_front(); oe = wr_obs.pop_front();
      checks++; if (oe !== ee) begin failures++; $display("FAIL fwd_wr: got %h expected %h", oe, ee); end
    end
    wr_exp.delete(); wr_obs.delete();
  endtask

  task automatic test_priority();
    sb_entry_t oe, ee;
    data_t ed;
    addr_t ta [3] = '{10'h040, 10'h044, 10'h040};
    be_t   tw [3] = '{4'hF, 4'hF, 4'b0001};
    data_t td [3] = '{32'h11111111, 32'h44444444, 32'h00000022};
    bus.wr_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      put_store(ta[i], tw[i], td[i]);
      wr_exp.push_back({ta[i], tw[i], td[i]});
      @(negedge clock); cycle();
    end
    idle();
    put_load(10'h040, 32'h11111122);
    @(negedge clock); cycle(); idle();
    @(negedge clock);
    ed = ld_exp.pop_front();
    checks++; if (bus.ld_rdata !== ed) begin failures++; $display("FAIL prio_youngest: got %h expected %h", bus.ld_rdata, ed); end
    cycle();
    bus.wr_hold = 1'b0;
    put_load(10'h040, 32'h11111122);
    @(negedge clock);
    checks++; if (bus.ram_waddr !== 10'h040) begin failures++; $display("FAIL prio_head_drain: got %h expected 040", bus.ram_waddr); end
    cycle(); idle();
    @(negedge clock);
    ed = ld_exp.pop_front();
    checks++; if (bus.ld_rdata !== ed) begin failures++; $display("FAIL prio_draining_head: got %h expected %h", bus.ld_rdata, ed); end
    cycle(); cycle();
    put_load(10'h040, 32'h11111122);
    @(negedge clock); cycle(); idle();
    @(negedge clock);
    ed = ld_exp.pop_front();
    checks++; if (bus.ld_rdata !== ed) begin failures++; $display("FAIL prio_ram_after: got %h expected %h", bus.ld_rdata, ed); end
    cycle();
    checks++; if (wr_obs.size() != wr_exp.size()) begin failures++; $display("FAIL prio_wr_count: got %0d expected %0d", wr_obs.size(), wr_exp.size()); end
    while (wr_exp.size() > 0 && wr_obs.size() > 0) begin
      ee = wr_exp.pop_front(); oe = wr_obs.pop_front();
      checks++; if (oe !== ee) begin failures++; $display("FAIL prio_wr: got %h expected %h", oe, ee); end
    end
    wr_exp.delete(); wr_obs.delete();
  endtask

  task automatic test_back_to_back();
    sb_entry_t oe, ee;
    addr_t ta [6] = '{10'h050, 10'h050, 10'h051, 10'h052, 10'h052, 10'h053};
    be_t   tw [6] = '{4'b0001, 4'b0010, 4'hF, 4'hF, 4'b0100, 4'hF};
    bus.wr_hold = 1'b0;
    for (int i = 0; i < 6; i++) begin
      put_store(ta[i], tw[i], 32'hC0DE0000 | 32'(i));
      wr_exp.push_back({ta[i], tw[i], 32'hC0DE0000 | 32'(i)});
      @(negedge clock);
      checks++; if (bus.st_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_%0d: got %b expected 1", i, bus.st_ready); end
      cycle();
    end
    idle();
    cycle();
    @(negedge clock);
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL b2b_empty: got %b expected 1", bus.empty); end
    cycle();
    checks++; if (wr_obs.size() != wr_exp.size()) begin failures++; $display("FAIL b2b_wr_count: got %0d expected %0d", wr_obs.size(), wr_exp.size()); end
    while (wr_exp.size() > 0 && wr_obs.size() > 0) begin
      ee = wr_exp.pop_front(); oe = wr_obs.pop_front();
      checks++; if (oe !== ee) begin failures++; $display("FAIL b2b_wr: got %h expected %h", oe, ee); end
    end
    wr_exp.delete(); wr_obs.delete();
  endtask

  task automatic test_reset_mid();
    data_t ed;
    preload(10'h060, 32'hCAFEF00D);
    bus.wr_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      put_store(10'h060 + 10'(i), 4'hF, 32'h12345678 + 32'(i));
      @(negedge clock); cycle();
    end
    idle();
    reset_n = 1'b0;
    @(negedge clock);
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL rst_mid_empty: got %b expected 1", bus.empty); end
    checks++; if (bus.st_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_ready: got %b expected 1", bus.st_ready); end
    cycle();
    reset_n = 1'b1;
    bus.wr_hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checks++; if (bus.ram_wen !== 1'b0) begin failures++; $display("FAIL rst_mid_wen_%0d: got %b expected 0", i, bus.ram_wen); end
      cycle();
    end
    put_load(10'h060, 32'hCAFEF00D);
    @(negedge clock); cycle(); idle();
    @(negedge clock);
    ed = ld_exp.pop_front();
    checks++; if (bus.ld_rdata !== ed) begin failures++; $display("FAIL rst_mid_raw_load: got %h expected %h", bus.ld_rdata, ed); end
    cycle();
    checks++; if (wr_obs.size() != 0) begin failures++; $display("FAIL rst_mid_wr_count: got %0d expected 0", wr_obs.size()); end
    wr_obs.delete();
  endtask

  initial begin
    test_reset();
    test_single_store();
    test_full();
    test_coalesce();
    test_forward();
    test_priority();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
